// File: rtl/elevator_call_panel_pkg.sv
// elevator_pkg: shared floor encodings, call-panel state enum and the
// floor-to-one-hot helper used by the elevator call panel.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;

    typedef enum logic [1:0] {
        FLR_A = 2'd0,
        FLR_B = 2'd1,
        FLR_C = 2'd2,
        FLR_D = 2'd3
    } floor_e;

    typedef enum logic [1:0] {
        MOVE  = 2'd0,
        DOOR  = 2'd1,
        CLOSE = 2'd2
    } panel_state_e;

    // Map a 2-bit floor number onto its request-line bit.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] f);
        logic [NUM_FLOORS-1:0] oh;
        oh = '0;
        case (floor_e'(f))
            FLR_A:   oh = 4'b0001;
            FLR_B:   oh = 4'b0010;
            FLR_C:   oh = 4'b0100;
            FLR_D:   oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/elevator_call_panel_call_edge_det.sv
// call_edge_det: turns the four level call buttons into one-cycle press
// pulses. Optional macro CALL_PANEL_SYNC_EN inserts a 2-flop synchroniser
// ahead of the edge detector; without it btn is taken as synchronous.
module call_edge_det
    import elevator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    output logic [NUM_FLOORS-1:0] press
);

    logic [NUM_FLOORS-1:0] btn_s;
    logic [NUM_FLOORS-1:0] btn_d_q;
    logic [NUM_FLOORS-1:0] btn_d_d;

`ifdef CALL_PANEL_SYNC_EN
    logic [NUM_FLOORS-1:0] sync1_q;
    logic [NUM_FLOORS-1:0] sync2_q;

    // Two-stage synchroniser; resets high so a held button is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;
`else
    assign btn_s = btn;
`endif

    // Delayed copy of the (possibly synchronised) buttons.
    always_comb begin
        btn_d_d = btn_s;
    end

    // Previous-sample register; all ones out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_d_q <= '1;
        end else begin
            btn_d_q <= btn_d_d;
        end
    end

    // Rising edge: high now, low on the previous sample.
    always_comb begin
        press = btn_s & ~btn_d_q;
    end

endmodule

// File: rtl/elevator_call_panel.sv
// elevator_call_panel: latches floor calls, drives the controller request
// lines, and runs the door service cycle (MOVE -> DOOR -> CLOSE) when the
// car settles at a floor with a pending call.
// Optional macro CALL_PANEL_SYNC_EN: synchronise btn before edge detect.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned DOOR_CYC   = 8,
    parameter int unsigned CW         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic [1:0] floor,
    output logic       ra,
    output logic       rb,
    output logic       rc,
    output logic       rd,
    output logic       door_open,
    output logic [3:0] pending
);

    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYC);
    localparam logic [CW-1:0] DOOR_LOAD  = CW'(DOOR_CYC - 1);

    logic [3:0]    press;
    logic [1:0]    floor_q,      floor_d;
    logic [CW-1:0] settle_cnt_q, settle_cnt_d;
    logic [CW-1:0] door_cnt_q,   door_cnt_d;
    logic [3:0]    pending_q,    pending_d;
    panel_state_e  state_q,      state_d;
    logic          arrived;
    logic [3:0]    req;

    call_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    // Settle tracking: arrival needs the floor stable for SETTLE_CYC cycles.
    always_comb begin
        floor_d = floor;
        if (floor != floor_q) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + CW'(1);
        end else begin
            settle_cnt_d = settle_cnt_q;
        end
        arrived = (settle_cnt_q == SETTLE_MAX) && (floor == floor_q);
    end

    // Pending calls: presses latch in every state; CLOSE clears the served
    // floor and wins over a same-cycle press of that floor.
    always_comb begin
        pending_d = pending_q | press;
        if (state_q == CLOSE) begin
            pending_d[floor_q] = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MOVE;
            floor_q      <= '0;
            settle_cnt_q <= SETTLE_MAX;
            door_cnt_q   <= '0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            settle_cnt_q <= settle_cnt_d;
            door_cnt_q   <= door_cnt_d;
            pending_q    <= pending_d;
        end
    end

    // Next-state and door timer.
    always_comb begin
        state_d    = state_q;
        door_cnt_d = door_cnt_q;
        case (state_q)
            MOVE: begin
                if (arrived && pending_q[floor]) begin
                    state_d    = DOOR;
                    door_cnt_d = DOOR_LOAD;
                end
            end
            DOOR: begin
                if (floor != floor_q) begin
                    state_d = MOVE;
                end else if (press[floor]) begin
                    door_cnt_d = DOOR_LOAD;
                end else if (door_cnt_q == '0) begin
                    state_d = CLOSE;
                end else begin
                    door_cnt_d = door_cnt_q - CW'(1);
                end
            end
            CLOSE: begin
                state_d = MOVE;
            end
            default: begin
                state_d = MOVE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        req       = '0;
        door_open = 1'b0;
        case (state_q)
            MOVE: begin
                req = pending_q;
            end
            DOOR: begin
                req       = pending_q & floor_onehot(floor_q);
                door_open = 1'b1;
            end
            CLOSE: begin
                req = pending_q & ~floor_onehot(floor_q);
            end
            default: begin
                req = '0;
            end
        endcase
    end

    assign {rd, rc, rb, ra} = req;
    assign pending          = pending_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel: a vector table for the basic
// service cycle plus hand-written multi-cycle sequences.
module tb_elevator_call_panel;
    import elevator_pkg::*;

`ifdef CALL_PANEL_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [1:0] floor;
    logic       ra, rb, rc, rd;
    logic       door_open;
    logic [3:0] pending;
    logic [3:0] req;

    int n_checks;
    int n_errors;

    assign req = {rd, rc, rb, ra};

    elevator_call_panel #(
        .SETTLE_CYC (4),
        .DOOR_CYC   (8),
        .CW         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .floor     (floor),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .rd        (rd),
        .door_open (door_open),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [3:0] btn;
        logic [1:0] flr;
        logic [3:0] req;
        logic       door;
        logic [3:0] pend;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] er, input logic ed,
                              input logic [3:0] ep);
        check({tag, ".req"},  {4'b0, req},       {4'b0, er});
        check({tag, ".door"}, {7'b0, door_open}, {7'b0, ed});
        check({tag, ".pend"}, {4'b0, pending},   {4'b0, ep});
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next.
    task automatic step(input logic [3:0] b, input logic [1:0] f);
        btn   = b;
        floor = f;
        @(posedge clk);
        #1;
    endtask

    // Reset with inputs applied, then idle long enough for the floor to settle.
    task automatic do_reset(input logic [3:0] b, input logic [1:0] f);
        rst_n = 1'b0;
        btn   = b;
        floor = f;
        @(posedge clk);
        #1;
        expect_out("reset", 4'b0000, 1'b0, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 6 + SL; i++) step(b, f);
    endtask

    int door_len;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        btn      = '0;
        floor    = '0;

        // Service at floor A, with a floor C press landing mid-door.
        vt[0]  = '{4'b0001, 2'd0, 4'b0001, 1'b0, 4'b0001};
        vt[1]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0001};
        vt[2]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0001};
        vt[3]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0001};
        vt[4]  = '{4'b0100, 2'd0, 4'b0001, 1'b1, 4'b0101};
        vt[5]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0101};
        vt[6]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0101};
        vt[7]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0101};
        vt[8]  = '{4'b0000, 2'd0, 4'b0001, 1'b1, 4'b0101};
        vt[9]  = '{4'b0000, 2'd0, 4'b0100, 1'b0, 4'b0101};
        vt[10] = '{4'b0000, 2'd0, 4'b0100, 1'b0, 4'b0100};
        vt[11] = '{4'b0000, 2'd0, 4'b0100, 1'b0, 4'b0100};

        // Button held through reset is not a press; a fresh press is.
        do_reset(4'b0100, 2'd0);
        expect_out("held", 4'b0000, 1'b0, 4'b0000);
        step(4'b0000, 2'd0);
        expect_out("held_drop", 4'b0000, 1'b0, 4'b0000);
        step(4'b0100, 2'd0);
        for (int i = 0; i < SL; i++) step(4'b0100, 2'd0);
        expect_out("repress", 4'b0100, 1'b0, 4'b0100);

        // Table-driven service cycle (timing assumes no synchroniser).
        if (SL == 0) begin
            do_reset(4'b0000, 2'd0);
            for (int i = 0; i < 12; i++) begin
                step(vt[i].btn, vt[i].flr);
                expect_out($sformatf("vec%0d", i), vt[i].req, vt[i].door, vt[i].pend);
            end
        end

        // Arrival after a move: floor_q picks up C on the first edge, door
        // opens on the 5th edge after that.
        do_reset(4'b0000, 2'd1);
        step(4'b1100, 2'd1);
        for (int i = 0; i < SL; i++) step(4'b0000, 2'd1);
        expect_out("mv_press", 4'b1100, 1'b0, 4'b1100);
        step(4'b0000, 2'd1);
        step(4'b0000, 2'd2);
        expect_out("mv_chg", 4'b1100, 1'b0, 4'b1100);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 2'd2);
            expect_out($sformatf("mv_settle%0d", i), 4'b1100, 1'b0, 4'b1100);
        end
        step(4'b0000, 2'd2);
        expect_out("mv_door", 4'b0100, 1'b1, 4'b1100);
        for (int i = 0; i < 7; i++) begin
            step(4'b0000, 2'd2);
            check($sformatf("mv_hold%0d", i), {7'b0, door_open}, 8'd1);
        end
        step(4'b0000, 2'd2);
        expect_out("mv_close", 4'b1000, 1'b0, 4'b1100);
        step(4'b0000, 2'd2);
        expect_out("mv_after", 4'b1000, 1'b0, 4'b1000);

        // Door extension at floor B: re-press while door_cnt == 2.
        do_reset(4'b0000, 2'd1);
        step(4'b0010, 2'd1);
        for (int i = 0; i < SL; i++) step(4'b0000, 2'd1);
        expect_out("ext_press", 4'b0010, 1'b0, 4'b0010);
        step(4'b0000, 2'd1);
        check("ext_open", {7'b0, door_open}, 8'd1);
        door_len = door_open ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            if (door_len == 6 - SL) step(4'b0010, 2'd1);
            else                    step(4'b0000, 2'd1);
            if (door_open) door_len++;
            else break;
        end
        check("ext_len", 8'(door_len), 8'd14);
        expect_out("ext_close", 4'b0000, 1'b0, 4'b0010);
        step(4'b0000, 2'd1);
        expect_out("ext_done", 4'b0000, 1'b0, 4'b0000);
        step(4'b0000, 2'd1);
        expect_out("ext_idle", 4'b0000, 1'b0, 4'b0000);

        // Abnormal movement during DOOR at floor D.
        do_reset(4'b0000, 2'd3);
        step(4'b1000, 2'd3);
        for (int i = 0; i < SL; i++) step(4'b0000, 2'd3);
        expect_out("abn_press", 4'b1000, 1'b0, 4'b1000);
        step(4'b0000, 2'd3);
        expect_out("abn_door", 4'b1000, 1'b1, 4'b1000);
        step(4'b0000, 2'd3);
        expect_out("abn_door2", 4'b1000, 1'b1, 4'b1000);
        step(4'b0000, 2'd2);
        expect_out("abn_move", 4'b1000, 1'b0, 4'b1000);
        step(4'b0000, 2'd2);
        expect_out("abn_stay", 4'b1000, 1'b0, 4'b1000);

        // Asynchronous reset mid-operation drops pending without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 4'b0000, 1'b0, 4'b0000);

        // Simultaneous presses all latch.
        do_reset(4'b0000, 2'd0);
        step(4'b1010, 2'd0);
        for (int i = 0; i < SL; i++) step(4'b0000, 2'd0);
        expect_out("simul", 4'b1010, 1'b0, 4'b1010);
        check("simul_rb", {7'b0, rb}, 8'd1);
        check("simul_rd", {7'b0, rd}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
